axi_rd: RTL and testbench

AXI read-channel master, the read-side companion of the AXI write stage. It arbitrates between the instruction cache and the data cache and issues one AR transaction at a time, either a line refill burst or a single uncached beat. It collects the R beats into a line buffer and returns the assembled line to the requester. It drives `read_unfinish` to the write stage so reads and writes never overlap, and it holds off data-cache reads while the write stage is busy.

---
 rtl/axi_rd.sv | 153 +++++++++++++++
 tb/tb_axi_rd.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd.sv
// axi_rd: AXI read-channel master shared by icache and dcache.
// One AR transaction in flight at a time (line refill burst or single beat),
// R beats collected into a line buffer, line returned with a one-cycle pulse.
// Optional build macro AXI_RD_RESP_CHECK_EN adds a sticky rd_err output that
// flags bad rresp, rid mismatch or rlast disagreeing with the beat counter.
module axi_rd #(
  parameter int BYTES_PER_LINE = 16,
  parameter int WORDS_PER_LINE = BYTES_PER_LINE / 4,
  parameter int PTR_WIDTH      = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1,
  parameter int LINE_WIDTH     = WORDS_PER_LINE * 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i_rd_req,
  output logic                  i_rd_rdy,
  input  logic                  i_burst,
  input  logic [31:0]           i_addr,
  output logic                  i_ret_valid,
  output logic [LINE_WIDTH-1:0] i_ret_data,
  input  logic                  d_rd_req,
  output logic                  d_rd_rdy,
  input  logic                  d_burst,
  input  logic [31:0]           d_addr,
  input  logic [1:0]            d_size,
  output logic                  d_ret_valid,
  output logic [LINE_WIDTH-1:0] d_ret_data,
  input  logic                  wr_idle,
  output logic                  read_unfinish,
  output logic [3:0]            arid,
  output logic [31:0]           araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [1:0]            arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [3:0]            rid,
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready
`ifdef AXI_RD_RESP_CHECK_EN
  ,
  output logic                  rd_err
`endif
);

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_AR   = 4'b0010,
    S_R    = 4'b0100,
    S_RESP = 4'b1000
  } state_e;

  localparam logic [PTR_WIDTH-1:0] LAST_PTR  = PTR_WIDTH'(WORDS_PER_LINE - 1);
  localparam logic [31:0]          LINE_MASK = ~(32'(BYTES_PER_LINE) - 32'd1);

  state_e                           state_q;
  logic                             src_q;    // 1 = dcache
  logic                             burst_q;
  logic [31:0]                      addr_q;
  logic [1:0]                       size_q;
  logic [PTR_WIDTH-1:0]             ptr_q;
  logic [WORDS_PER_LINE-1:0][31:0]  buf_q;

  logic st_idle, d_accept, i_accept, r_beat, last_beat;

  // Acceptance is gated by resetn so nothing looks ready while reset is held.
  assign st_idle       = resetn & (state_q == S_IDLE);
  assign d_accept      = st_idle & d_rd_req & wr_idle;
  assign i_accept      = st_idle & i_rd_req & ~d_accept;
  assign d_rd_rdy      = st_idle & wr_idle;
  assign i_rd_rdy      = st_idle & ~d_accept;
  // Combinational so the write stage sees the block in the accept cycle itself.
  assign read_unfinish = (state_q != S_IDLE) | i_accept | d_accept;

  // AR payload comes only from latched request fields, so it is stable until arready.
  assign arvalid = (state_q == S_AR);
  assign arid    = {3'b000, src_q};
  assign araddr  = burst_q ? (addr_q & LINE_MASK) : addr_q;
  assign arlen   = burst_q ? 8'(WORDS_PER_LINE - 1) : 8'd0;
  assign arsize  = burst_q ? 3'd2 : {1'b0, size_q};
  assign arburst = burst_q ? 2'b01 : 2'b00;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  assign rready    = (state_q == S_R);
  assign r_beat    = rready & rvalid;
  // Sequencing follows the beat counter only; rlast is not trusted.
  assign last_beat = ~burst_q | (ptr_q == LAST_PTR);

  assign i_ret_valid = (state_q == S_RESP) & ~src_q;
  assign d_ret_valid = (state_q == S_RESP) & src_q;
  assign i_ret_data  = buf_q;
  assign d_ret_data  = buf_q;

  // Read FSM: accept, issue AR, collect beats, one-cycle return pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      src_q   <= 1'b0;
      burst_q <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      ptr_q   <= '0;
      buf_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (d_accept | i_accept) begin
            src_q   <= d_accept;
            burst_q <= d_accept ? d_burst : i_burst;
            addr_q  <= d_accept ? d_addr : i_addr;
            size_q  <= d_accept ? d_size : 2'd2;
            ptr_q   <= '0;
            buf_q   <= '0;   // single reads rely on the upper words being zero
            state_q <= S_AR;
          end
        end
        S_AR: if (arready) state_q <= S_R;
        S_R: begin
          if (r_beat) begin
            buf_q[ptr_q] <= rdata;
            ptr_q        <= ptr_q + 1'b1;
            if (last_beat) begin
              ptr_q   <= '0;
              state_q <= S_RESP;
            end
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef AXI_RD_RESP_CHECK_EN
  // Sticky protocol error flag; only reset clears it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rd_err <= 1'b0;
    else if (r_beat && ((rresp != 2'b00) || (rid != arid) || (rlast != last_beat)))
      rd_err <= 1'b1;
  end
`else
  logic unused_rsp;
  assign unused_rsp = ^{rid, rresp, rlast};
`endif

endmodule

// File: tb/tb_axi_rd.sv
// tb_axi_rd: randomized bench for axi_rd with an AXI slave model and
// expected AR payload / returned line computed from the request.
module tb_axi_rd;
  localparam int BPL = 16;
  localparam int WPL = BPL / 4;
  localparam int LW  = WPL * 32;

  logic          clk = 0, resetn = 0;
  logic          i_rd_req = 0, i_burst = 0, d_rd_req = 0, d_burst = 0, wr_idle = 1;
  logic [31:0]   i_addr = 0, d_addr = 0;
  logic [1:0]    d_size = 0;
  logic          i_rd_rdy, d_rd_rdy, i_ret_valid, d_ret_valid, read_unfinish;
  logic [LW-1:0] i_ret_data, d_ret_data;
  logic [3:0]    arid;
  logic [31:0]   araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize, arprot;
  logic [1:0]    arburst, arlock;
  logic [3:0]    arcache;
  logic          arvalid, arready = 0;
  logic [3:0]    rid = 0;
  logic [31:0]   rdata = 0;
  logic [1:0]    rresp = 0;
  logic          rlast = 0, rvalid = 0, rready;
`ifdef AXI_RD_RESP_CHECK_EN
  logic          rd_err;
`endif

  int n_chk = 0, n_fail = 0;

  axi_rd #(.BYTES_PER_LINE(BPL)) dut (
    .clk(clk), .resetn(resetn),
    .i_rd_req(i_rd_req), .i_rd_rdy(i_rd_rdy), .i_burst(i_burst), .i_addr(i_addr),
    .i_ret_valid(i_ret_valid), .i_ret_data(i_ret_data),
    .d_rd_req(d_rd_req), .d_rd_rdy(d_rd_rdy), .d_burst(d_burst), .d_addr(d_addr),
    .d_size(d_size), .d_ret_valid(d_ret_valid), .d_ret_data(d_ret_data),
    .wr_idle(wr_idle), .read_unfinish(read_unfinish),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
`ifdef AXI_RD_RESP_CHECK_EN
    , .rd_err(rd_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic issue(input bit src, input bit burst, input logic [31:0] addr, input logic [1:0] size);
    @(negedge clk);
    if (src) begin d_rd_req = 1; d_burst = burst; d_addr = addr; d_size = size; end
    else     begin i_rd_req = 1; i_burst = burst; i_addr = addr; end
    #1;
    chk(src ? "d_rd_rdy" : "i_rd_rdy", src ? d_rd_rdy : i_rd_rdy, 1);
    chk("unfinish_acc", read_unfinish, 1);
    @(posedge clk); #1;
    i_rd_req = 0; d_rd_req = 0;
  endtask

  // Slave side of one accepted request: AR wait, beats with gaps, return check.
  task automatic serve(input bit src, input bit burst, input logic [31:0] addr,
                       input logic [1:0] size, input int ar_delay, input int gap_max, input bit fixed);
    logic [31:0]   exp_addr, w;
    logic [LW-1:0] exp_line;
    int            n, g;
    exp_addr = burst ? (addr - (addr % BPL)) : addr;
    n        = burst ? WPL : 1;
    exp_line = '0;
    for (int c = 0; c <= ar_delay; c++) begin
      @(negedge clk); arready = (c == ar_delay); #1;
      chk("arvalid", arvalid, 1);
      chk("araddr", araddr, exp_addr);
      chk("arlen", arlen, burst ? WPL - 1 : 0);
      chk("arsize", arsize, burst ? 2 : {1'b0, size});
      chk("arburst", arburst, burst ? 1 : 0);
      chk("arid", arid, src);
      chk("ar_zero", {arlock, arcache, arprot}, 0);
    end
    @(posedge clk); #1 arready = 0;
    for (int b = 0; b < n; b++) begin
      g = $urandom_range(gap_max, 0);
      for (int k = 0; k < g; k++) begin
        @(negedge clk); rvalid = 0; rdata = $urandom; #1;
        chk("rready_gap", rready, 1);
        chk("ret_gap", {i_ret_valid, d_ret_valid}, 0);
      end
      @(negedge clk);
      w = fixed ? 32'(b + 1) * 32'h11 : $urandom;
      rvalid = 1; rdata = w; rlast = (b == n - 1); rid = {3'b0, src}; rresp = 0;
      exp_line[32*b +: 32] = w;
      #1 chk("rready", rready, 1);
      chk("ret_early", {i_ret_valid, d_ret_valid}, 0);
    end
    @(negedge clk); rvalid = 0; rlast = 0; #1;
    chk("ret_valid", {i_ret_valid, d_ret_valid}, src ? 2'b01 : 2'b10);
    chk("ret_data", src ? d_ret_data : i_ret_data, exp_line);
    chk("unfinish_resp", read_unfinish, 1);
    @(negedge clk); #1;
    chk("ret_pulse", {i_ret_valid, d_ret_valid}, 0);
  endtask

  initial begin
    bit          s, bu;
    logic [31:0] a;
    logic [1:0]  sz;
    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valids", {arvalid, rready, i_ret_valid, d_ret_valid, i_rd_rdy, d_rd_rdy}, 0);
    chk("rst_unfinish", read_unfinish, 0);
    @(negedge clk); resetn = 1; #1;
    chk("idle_rdy", {i_rd_rdy, d_rd_rdy}, 2'b11);
    chk("idle_unfinish", read_unfinish, 0);

    // icache burst, unaligned address, arready late, known data
    issue(0, 1, 32'h1c000014, 2);
    serve(0, 1, 32'h1c000014, 2, 3, 0, 1);
    chk("tp1_line", i_ret_data, 128'h00000044_00000033_00000022_00000011);

    // simultaneous requests: dcache first, icache next
    @(negedge clk);
    i_rd_req = 1; i_burst = 1; i_addr = 32'h00001234;
    d_rd_req = 1; d_burst = 1; d_addr = 32'h80000048; wr_idle = 1;
    #1;
    chk("prio_d_rdy", d_rd_rdy, 1);
    chk("prio_i_rdy", i_rd_rdy, 0);
    @(posedge clk); #1 d_rd_req = 0;
    serve(1, 1, 32'h80000048, 2, 1, 1, 0);
    chk("i_wait_rdy", i_rd_rdy, 1);
    @(posedge clk); #1 i_rd_req = 0;
    serve(0, 1, 32'h00001234, 2, 0, 1, 0);

    // dcache held off by busy write stage, icache gets through
    @(negedge clk); d_rd_req = 1; d_burst = 1; d_addr = 32'h40; wr_idle = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("busy_d_rdy", d_rd_rdy, 0);
      chk("busy_arvalid", arvalid, 0);
      if (c == 4) begin
        i_rd_req = 1; i_burst = 0; i_addr = 32'h00000108; #1;
        chk("busy_i_rdy", i_rd_rdy, 1);
        @(posedge clk); #1 i_rd_req = 0;
      end else begin
        chk("busy_unfinish", read_unfinish, 0);
        @(negedge clk);
      end
    end
    serve(0, 0, 32'h00000108, 2, 0, 0, 0);
    d_rd_req = 0; wr_idle = 1;

    // uncached byte read
    issue(1, 0, 32'h1fd00003, 0);
    @(negedge clk); #1;
    chk("ub_araddr", araddr, 32'h1fd00003);
    chk("ub_arsize", arsize, 0);
    arready = 1;
    @(posedge clk); #1 arready = 0;
    @(negedge clk); rvalid = 1; rdata = 32'hAB000000; rid = 1; rlast = 1;
    @(negedge clk); rvalid = 0; rlast = 0; #1;
    chk("ub_valid", d_ret_valid, 1);
    chk("ub_data", d_ret_data, 128'h0000_0000_0000_0000_0000_0000_AB00_0000);

    // burst with 2-cycle gaps between beats
    issue(1, 1, 32'h2000_0030, 2);
    serve(1, 1, 32'h2000_0030, 2, 0, 2, 0);

    // reset in the middle of a burst
    issue(0, 1, 32'h3000_0000, 2);
    @(negedge clk); arready = 1;
    @(posedge clk); #1 arready = 0;
    for (int b = 0; b < 2; b++) begin @(negedge clk); rvalid = 1; rdata = $urandom; end
    @(negedge clk); rvalid = 0; resetn = 0; #1;
    chk("mid_rst_valids", {arvalid, rready, i_ret_valid, d_ret_valid, i_rd_rdy, d_rd_rdy}, 0);
    chk("mid_rst_unfinish", read_unfinish, 0);
    @(negedge clk); resetn = 1;
    issue(0, 1, 32'h3000_0004, 2);
    serve(0, 1, 32'h3000_0004, 2, 1, 1, 0);

    // randomized mix
    for (int t = 0; t < 12; t++) begin
      s  = 1'($urandom);
      bu = 1'($urandom);
      a  = $urandom;
      sz = s ? 2'($urandom_range(2, 0)) : 2'd2;
      issue(s, bu, a, sz);
      serve(s, bu, a, sz, $urandom_range(3, 0), 2, 0);
    end
`ifdef AXI_RD_RESP_CHECK_EN
    chk("rd_err", rd_err, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
